// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port data-memory controller in front of a single-port,
// word-addressed data_mem. Round-robin arbitration, byte-to-word address
// conversion, sub-word read-modify-write stores, sign/zero-extended loads,
// and fault responses for misaligned or out-of-range requests.
module dmem_ctrl #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [1:0]  req_valid_in,
  output logic [1:0]  req_ready_out,
  input  logic [1:0]  req_we_in,
  input  logic [3:0]  req_size_in,
  input  logic [1:0]  req_unsigned_in,
  input  logic [63:0] req_addr_in,
  input  logic [63:0] req_wdata_in,
  output logic [1:0]  rsp_valid_out,
  output logic [31:0] rsp_rdata_out,
  output logic        rsp_err_out,
  output logic        mem_store_en_out,
  output logic        mem_load_en_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDWAIT,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // One past the last legal byte address.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  state_t      state;
  logic        last_grant;

  // Request fields captured on accept
  logic        cap_port;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [1:0]  cap_lane;
  logic [15:0] cap_wdata;

  // Arbitration and the selected requester's fields
  logic [1:0]  grant;
  logic        sel;
  logic        accept;
  logic        s_we;
  logic [1:0]  s_size;
  logic        s_uns;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_fault;

  // Read-data datapath used in RDWAIT
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Round-robin grant: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    grant = '0;
    case (req_valid_in)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign req_ready_out = (state == IDLE) ? grant : '0;
  assign accept        = |(req_valid_in & req_ready_out);
  assign sel           = grant[1];

  // Mux the granted port's request and classify faults
  always_comb begin
    s_we    = sel ? req_we_in[1]         : req_we_in[0];
    s_size  = sel ? req_size_in[3:2]     : req_size_in[1:0];
    s_uns   = sel ? req_unsigned_in[1]   : req_unsigned_in[0];
    s_addr  = sel ? req_addr_in[63:32]   : req_addr_in[31:0];
    s_wdata = sel ? req_wdata_in[63:32]  : req_wdata_in[31:0];
    s_fault = (s_size == SZ_BAD)
           || ((s_size == SZ_HALF) && s_addr[0])
           || ((s_size == SZ_WORD) && (s_addr[1:0] != 2'b00))
           || ({1'b0, s_addr} >= ADDR_LIMIT);
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    byte_val = mem_rdata_in[{cap_lane, 3'b000} +: 8];
    half_val = mem_rdata_in[{cap_lane[1], 4'b0000} +: 16];
    case (cap_size)
      SZ_BYTE: load_ext = {{24{byte_val[7] & ~cap_uns}}, byte_val};
      SZ_HALF: load_ext = {{16{half_val[15] & ~cap_uns}}, half_val};
      default: load_ext = mem_rdata_in;
    endcase
    merged = mem_rdata_in;
    if (cap_size == SZ_BYTE)
      merged[{cap_lane, 3'b000} +: 8] = cap_wdata[7:0];
    else
      merged[{cap_lane[1], 4'b0000} +: 16] = cap_wdata[15:0];
  end

  // Transaction FSM with registered strobes and response outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      cap_port         <= 1'b0;
      cap_we           <= 1'b0;
      cap_size         <= '0;
      cap_uns          <= 1'b0;
      cap_lane         <= '0;
      cap_wdata        <= '0;
      rsp_valid_out    <= '0;
      rsp_rdata_out    <= '0;
      rsp_err_out      <= 1'b0;
      mem_store_en_out <= 1'b0;
      mem_load_en_out  <= 1'b0;
      mem_addr_out     <= '0;
      mem_wdata_out    <= '0;
    end else begin
      mem_store_en_out <= 1'b0;
      mem_load_en_out  <= 1'b0;
      rsp_valid_out    <= '0;
      rsp_rdata_out    <= '0;
      rsp_err_out      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= sel;
            cap_port   <= sel;
            cap_we     <= s_we;
            cap_size   <= s_size;
            cap_uns    <= s_uns;
            cap_lane   <= s_addr[1:0];
            cap_wdata  <= s_wdata[15:0];
            if (s_fault) begin
              state         <= RESP;
              rsp_valid_out <= {sel, ~sel};
              rsp_err_out   <= 1'b1;
            end else if (s_we && (s_size == SZ_WORD)) begin
              state            <= WR;
              mem_store_en_out <= 1'b1;
              mem_addr_out     <= {2'b00, s_addr[31:2]};
              mem_wdata_out    <= s_wdata;
            end else begin
              // Loads and sub-word stores both start with a word read
              state           <= RD;
              mem_load_en_out <= 1'b1;
              mem_addr_out    <= {2'b00, s_addr[31:2]};
            end
          end
        end
        RD: state <= RDWAIT;
        RDWAIT: begin
          if (cap_we) begin
            state            <= WR;
            mem_store_en_out <= 1'b1;
            mem_wdata_out    <= merged;
          end else begin
            state         <= RESP;
            rsp_valid_out <= {cap_port, ~cap_port};
            rsp_rdata_out <= load_ext;
          end
        end
        WR: begin
          state         <= RESP;
          rsp_valid_out <= {cap_port, ~cap_port};
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven bench for dmem_ctrl with a behavioural data_mem
// and a response scoreboard, plus hand-written reset and arbitration sequences.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid_in;
  logic [1:0]  req_ready_out;
  logic [1:0]  req_we_in;
  logic [3:0]  req_size_in;
  logic [1:0]  req_unsigned_in;
  logic [63:0] req_addr_in;
  logic [63:0] req_wdata_in;
  logic [1:0]  rsp_valid_out;
  logic [31:0] rsp_rdata_out;
  logic        rsp_err_out;
  logic        mem_store_en_out;
  logic        mem_load_en_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in;

  dmem_ctrl #(.DEPTH(1024)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_we_in        (req_we_in),
    .req_size_in      (req_size_in),
    .req_unsigned_in  (req_unsigned_in),
    .req_addr_in      (req_addr_in),
    .req_wdata_in     (req_wdata_in),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_rdata_out    (rsp_rdata_out),
    .rsp_err_out      (rsp_err_out),
    .mem_store_en_out (mem_store_en_out),
    .mem_load_en_out  (mem_load_en_out),
    .mem_addr_out     (mem_addr_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_rdata_in     (mem_rdata_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data_mem with a backdoor write port for preloading
  logic [31:0] mem_arr [1024];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_addr] <= bd_data;
    else if (mem_store_en_out) mem_arr[mem_addr_out[9:0]] <= mem_wdata_out;
    if (mem_load_en_out) mem_rdata_in <= mem_arr[mem_addr_out[9:0]];
  end

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          pre_idx;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          exp_loads;
    int          exp_stores;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   load_cnt = 0;
  int   load_cyc = 0;
  logic [31:0] load_addr = '0;
  int   store_cnt = 0;
  int   store_cyc = 0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Advance to the next falling edge and sample strobes and responses
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (mem_load_en_out) begin
      load_cnt++;
      load_cyc  = cyc;
      load_addr = mem_addr_out;
    end
    if (mem_store_en_out) begin
      store_cnt++;
      store_cyc  = cyc;
      store_addr = mem_addr_out;
      store_data = mem_wdata_out;
    end
    if (rsp_valid_out != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid_out), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_port", 32'(rsp_valid_out), 32'd1 << e.port);
        check("rsp_rdata", rsp_rdata_out, e.rdata);
        check("rsp_err", 32'(rsp_err_out), 32'(e.err));
        check("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if ((rsp_rdata_out != 32'd0) || rsp_err_out) begin
      check("idle_rsp_data", rsp_rdata_out | 32'(rsp_err_out), 32'd0);
    end
  endtask

  task automatic drive_port(input int p, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    req_we_in[p]            = we;
    req_size_in[2*p +: 2]   = size;
    req_unsigned_in[p]      = uns;
    req_addr_in[32*p +: 32] = addr;
    req_wdata_in[32*p +: 32] = wdata;
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_addr = 10'(idx);
    bd_data = data;
    tick();
    bd_we   = 1'b0;
  endtask

  // Present a request until accepted; base is the cycle of the accepting edge's negedge-before
  task automatic issue(input vec_t v, input bit push, output int base);
    base = -1;
    drive_port(v.port, v.we, v.size, v.uns, v.addr, v.wdata);
    req_valid_in = '0;
    req_valid_in[v.port] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready_out[v.port]) begin
        base = cyc;
        if (push) sb.push_back('{v.port, v.exp_rdata, v.exp_err, cyc + v.lat});
        tick();
        break;
      end
      tick();
    end
    req_valid_in = '0;
    if (base < 0) fail_now("accept_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      fail_now("rsp_timeout");
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    int l0;
    int s0;
    preload(v.pre_idx, v.pre);
    l0 = load_cnt;
    s0 = store_cnt;
    issue(v, 1'b1, base);
    drain();
    check("load_count", 32'(load_cnt - l0), 32'(v.exp_loads));
    check("store_count", 32'(store_cnt - s0), 32'(v.exp_stores));
    if (v.exp_loads != 0) begin
      check("load_cycle", 32'(load_cyc - base), 32'd1);
      check("load_addr", load_addr, v.addr >> 2);
    end
    if (v.exp_stores != 0) begin
      check("store_cycle", 32'(store_cyc - base), 32'(v.lat - 1));
      check("store_addr", store_addr, v.addr >> 2);
      check("store_data", store_data, v.exp_wdata);
      check("mem_word", mem_arr[v.addr[11:2]], v.exp_wdata);
    end
  endtask

  vec_t vecs[19];
  vec_t v;
  int   base;
  int   l0;
  int   s0;
  int   grants[4];
  int   n;

  initial begin
    rst_n           = 1'b0;
    req_valid_in    = '0;
    req_we_in       = '0;
    req_size_in     = '0;
    req_unsigned_in = '0;
    req_addr_in     = '0;
    req_wdata_in    = '0;
    bd_we           = 1'b0;
    bd_addr         = '0;
    bd_data         = '0;

    //            port we    size   uns   addr          wdata         idx  pre           rdata         err  lat ld st wdata-to-mem
    vecs[0]  = '{0, 1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0,        4,   32'h80FF7F01, 32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h0};
    vecs[1]  = '{0, 1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0,        4,   32'h80FF7F01, 32'h00000080, 1'b0, 3, 1, 0, 32'h0};
    vecs[2]  = '{0, 1'b0, 2'b01, 1'b0, 32'h00000012, 32'h0,        4,   32'h80FF7F01, 32'hFFFF80FF, 1'b0, 3, 1, 0, 32'h0};
    vecs[3]  = '{1, 1'b0, 2'b01, 1'b1, 32'h00000010, 32'h0,        4,   32'h80FF7F01, 32'h00007F01, 1'b0, 3, 1, 0, 32'h0};
    vecs[4]  = '{1, 1'b0, 2'b00, 1'b0, 32'h00000011, 32'h0,        4,   32'h80FF7F01, 32'h0000007F, 1'b0, 3, 1, 0, 32'h0};
    vecs[5]  = '{0, 1'b0, 2'b00, 1'b0, 32'h00000012, 32'h0,        4,   32'h80FF7F01, 32'hFFFFFFFF, 1'b0, 3, 1, 0, 32'h0};
    vecs[6]  = '{1, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        4,   32'h80FF7F01, 32'h80FF7F01, 1'b0, 3, 1, 0, 32'h0};
    vecs[7]  = '{0, 1'b0, 2'b01, 1'b1, 32'h00000012, 32'h0,        4,   32'h80FF7F01, 32'h000080FF, 1'b0, 3, 1, 0, 32'h0};
    vecs[8]  = '{0, 1'b1, 2'b00, 1'b0, 32'h00000011, 32'h000000AB, 4,   32'h11223344, 32'h0,        1'b0, 4, 1, 1, 32'h1122AB44};
    vecs[9]  = '{1, 1'b1, 2'b01, 1'b0, 32'h00000012, 32'h1234BEEF, 4,   32'h11223344, 32'h0,        1'b0, 4, 1, 1, 32'hBEEF3344};
    vecs[10] = '{0, 1'b1, 2'b00, 1'b0, 32'h00000013, 32'hFFFFFF99, 4,   32'h11223344, 32'h0,        1'b0, 4, 1, 1, 32'h99223344};
    vecs[11] = '{1, 1'b1, 2'b10, 1'b0, 32'h00000010, 32'hCAFEF00D, 4,   32'h11223344, 32'h0,        1'b0, 2, 0, 1, 32'hCAFEF00D};
    vecs[12] = '{0, 1'b0, 2'b10, 1'b0, 32'h00000012, 32'h0,        4,   32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    vecs[13] = '{0, 1'b1, 2'b01, 1'b0, 32'h00000011, 32'h0000FFFF, 4,   32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    vecs[14] = '{1, 1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0,        4,   32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    vecs[15] = '{0, 1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0,        4,   32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    vecs[16] = '{1, 1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000077, 4,   32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    vecs[17] = '{0, 1'b0, 2'b10, 1'b0, 32'h00000FFC, 32'h0,        1023, 32'h5A5AA5A5, 32'h5A5AA5A5, 1'b0, 3, 1, 0, 32'h0};
    vecs[18] = '{1, 1'b0, 2'b00, 1'b1, 32'h00000FFF, 32'h0,        1023, 32'h5A5AA5A5, 32'h0000005A, 1'b0, 3, 1, 0, 32'h0};

    // Reset values
    repeat (3) tick();
    check("rst_ready", 32'(req_ready_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_out, 32'd0);
    check("rst_rsp_err", 32'(rsp_err_out), 32'd0);
    check("rst_store_en", 32'(mem_store_en_out), 32'd0);
    check("rst_load_en", 32'(mem_load_en_out), 32'd0);
    check("rst_mem_addr", mem_addr_out, 32'd0);
    check("rst_mem_wdata", mem_wdata_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // First transaction after reset: port 0 word store to 0x10
    v = '{0, 1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 4, 32'h0, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF};
    run_vec(v);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during RDWAIT of a byte store: no write, no response
    preload(4, 32'h11223344);
    l0 = load_cnt;
    s0 = store_cnt;
    v = '{0, 1'b1, 2'b00, 1'b0, 32'h00000010, 32'h00000055, 4, 32'h11223344, 32'h0, 1'b0, 4, 1, 1, 32'h0};
    issue(v, 1'b0, base);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_store_en", 32'(mem_store_en_out), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_loads", 32'(load_cnt - l0), 32'd1);
    check("midrst_stores", 32'(store_cnt - s0), 32'd0);
    check("midrst_mem", mem_arr[4], 32'h11223344);
    v = '{1, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0, 4, 32'h11223344, 32'h11223344, 1'b0, 3, 1, 0, 32'h0};
    run_vec(v);

    // Arbitration from reset: both ports hold word loads
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    preload(4, 32'h01020304);
    preload(8, 32'h05060708);
    drive_port(0, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0);
    drive_port(1, 1'b0, 2'b10, 1'b0, 32'h00000020, 32'h0);
    for (int k = 0; k < 4; k++) grants[k] = -1;
    n = 0;
    req_valid_in = 2'b11;
    for (int i = 0; i < 60 && n < 4; i++) begin
      #1;
      if (req_ready_out == 2'b11) begin
        check("ready_onehot", 32'(req_ready_out), 32'd1);
      end else if (req_ready_out != 2'b00) begin
        grants[n] = req_ready_out[1] ? 1 : 0;
        sb.push_back('{grants[n], (grants[n] == 1) ? 32'h05060708 : 32'h01020304, 1'b0, cyc + 3});
        n++;
      end
      tick();
    end
    req_valid_in = '0;
    drain();
    if (n < 4) fail_now("arb_grants");
    for (int k = 0; k < 4; k++) check("arb_grant_order", 32'(grants[k]), 32'(k % 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Two-port data-memory controller between the requesters (port 0 = core load/store unit, port 1 = debug/DMA) and the single-port word-addressed `data_mem` (1024 x 32). It does the following:

- Arbitrates round-robin between the two ports.
- Converts byte addresses to word indices.
- Performs byte/halfword stores as read-modify-write.
- Sign- or zero-extends sub-word loads.
- Rejects misaligned and out-of-range accesses.

One transaction is in flight at a time.

## Interface
Parameters:
- `DEPTH`, 1024: memory depth in 32-bit words. Legal byte addresses are 0 .. 4*DEPTH-1.

Ports (`[i]` / slice `i` refers to requester i):
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_n_in`  in  1  reset; one clock, asynchronous and active-low.
- `req_valid_in`  in  2  request valid per port.
- `req_ready_out`  out  2  request accepted this cycle when valid & ready.
- `req_we_in`  in  2  1 = store, 0 = load.
- `req_size_in`  in  4  2 bits per port: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_in`  in  2  load zero-extend (1) or sign-extend (0).
- `req_addr_in`  in  64  32-bit byte address per port; port i uses bits [32i+31:32i].
- `req_wdata_in`  in  64  store data per port, right-aligned.
- `rsp_valid_out`  out  2  one-cycle response pulse to the granted port.
- `rsp_rdata_out`  out  32  extended load data; 0 for stores and errors.
- `rsp_err_out`  out  1  access fault, valid with `rsp_valid_out`.
- `mem_store_en_out`  out  1  one-cycle store strobe to `data_mem`.
- `mem_load_en_out`  out  1  one-cycle load strobe.
- `mem_addr_out`  out  32  word index = {2'b0, addr[31:2]}.
- `mem_wdata_out`  out  32  full word to store.
- `mem_rdata_in`  in  32  memory read data, valid the cycle after `mem_load_en_out`.

## Operation
- **FSM states:** IDLE, RD, RDWAIT, WR, RESP.
- **Ready:** `req_ready_out[i]` = (state==IDLE) & grant[i]. It is combinational from the valids and `last_grant`.
- **Arbitration:**
  - If only one port is valid, it is granted.
  - If both are valid, the port not equal to `last_grant` is granted.
  - `last_grant` updates on accept and resets to 1, so port 0 wins the first tie.
- **Capture on accept:** port id, we, size, unsigned, addr and wdata are registered.
- **Fault:** any of the following raises a fault:
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= 4*DEPTH.

  A fault goes IDLE → RESP with err=1, no memory strobe and rdata=0.
- **Load:** IDLE → RD (`mem_load_en_out`=1) → RDWAIT (capture `mem_rdata_in`, extract and extend) → RESP.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign extension from bit 7 or 15 unless unsigned; word loads are passed through.
- **Word store:** IDLE → WR (`mem_store_en_out`=1, wdata) → RESP.
- **Byte/half store:** IDLE → RD → RDWAIT (merge the wdata low byte/half into the captured word at its lane; other bytes unchanged) → WR (merged word) → RESP.
- **RESP:** `rsp_valid_out[port]`=1 for one cycle, then IDLE. There is no response back-pressure; the requester must accept the pulse.
- **Outputs outside their strobe cycles:**
  - strobes are 0;
  - `mem_addr_out` and `mem_wdata_out` hold their last value;
  - `rsp_rdata_out` and `rsp_err_out` are 0 except in RESP.
- **Reset values:** every output 0; state IDLE; `last_grant`=1. Reset mid-transaction abandons it:
  - no response is issued;
  - a sub-word store that has not reached WR leaves memory unmodified.

## Timing
With the accept edge at cycle T:
- **Fault:** `rsp_valid` at T+1.
- **Word store:** `mem_store_en` at T+1, `rsp_valid` at T+2.
- **Load:** `mem_load_en` at T+1, data captured at T+2, `rsp_valid` at T+3.
- **Sub-word store:** load at T+1, capture at T+2, store at T+3, `rsp_valid` at T+4.
- **Next accept:** earliest one cycle after RESP. Word-store throughput is 1 per 3 cycles.
- **Registered outputs:** all outputs except `req_ready_out` are registered.

## Test plan
- **Reset values:** hold `rst_n_in`=0 → all outputs 0. Release with port 0 word store addr 0x10, data 0xDEADBEEF → `mem_addr_out`=4 and store strobe at T+1, `rsp_valid_out`=01 at T+2, err=0.
- **Sub-word loads:** memory word 4 = 0x80FF7F01.
  - Byte load addr 0x13 signed → rdata 0xFFFFFF80.
  - Byte load addr 0x13 unsigned → 0x00000080.
  - Half load addr 0x12 signed → 0xFFFF80FF.
  - Each response arrives at T+3.
- **Byte store RMW:** memory word 4 = 0x11223344; byte store 0xAB at addr 0x11 → load strobe at T+1, store strobe at T+3 with wdata 0x1122AB44, response at T+4.
- **Faults:**
  - word addr 0x12 → err at T+1, no strobes;
  - half addr 0x11 → err;
  - size 11 → err;
  - addr 0x1000 with DEPTH=1024 → err.
- **Arbitration:** both ports hold valid with continuous word loads → grants alternate 0,1,0,1; first grant goes to port 0; each response pulses only on the owning port.
- **Reset mid-transaction:** assert `rst_n_in` during RDWAIT of a byte store → no WR strobe, no response, memory word unchanged, controller accepts a new request after release.
